// File: rtl/lsu_align_if.sv
// lsu_align_if: CPU-side and memory-side signal bundle for lsu_align
// Signals:
//   CPU side    - start, op, addr, wdata (requests) / busy, done, rdata, err (status)
//   memory side - mem_req, mem_we, mem_addr, mem_be, mem_wdata (bus cycle) / mem_rdata, mem_ack (response)
// Modports: slave is the alignment unit, master is the CPU plus memory environment
interface lsu_align_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport slave (
        input  start, op, addr, wdata, mem_rdata, mem_ack,
        output busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport master (
        output start, op, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit with a req/ack word-bus handshake
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - lsu_align_if.slave: CPU request/status and word-wide memory bus
// Parameters:
//   TIMEOUT - REQ cycles allowed before the access aborts with err (1..255)
// Configuration:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses complete
//   immediately with err and no bus cycle; otherwise the unusable low address
//   bits are ignored
module lsu_align #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic        clk,
    input logic        reset,
    lsu_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        in_word, in_half, in_store, q_store, trap;
    logic [1:0]  in_off;
    logic [31:0] lane, load_val;
    assign in_word  = bus.op == 3'd0 || bus.op == 3'd5;
    assign in_half  = bus.op == 3'd1 || bus.op == 3'd2 || bus.op == 3'd6;
    assign in_store = bus.op[2] & |bus.op[1:0];
    // byte offset the lane is taken from; half/word ops drop the bits they cannot use
    assign in_off   = in_word ? 2'b00 : in_half ? {bus.addr[1], 1'b0} : bus.addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = in_word ? |bus.addr[1:0] : in_half & bus.addr[0];
`else
    assign trap = 1'b0;
`endif
    assign q_store  = op_q[2] & |op_q[1:0];
    assign lane     = bus.mem_rdata >> {off_q, 3'b000};
    assign load_val = op_q == 3'd3 ? {{24{lane[7]}}, lane[7:0]}
                    : op_q == 3'd4 ? {24'h0, lane[7:0]}
                    : op_q == 3'd1 ? {{16{lane[15]}}, lane[15:0]}
                    : op_q == 3'd2 ? {16'h0, lane[15:0]}
                    : lane;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        if (state_q == IDLE) begin
            if (bus.start) begin
                op_d  = bus.op;
                off_d = in_off;
                cnt_d = '0;
                if (trap) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d = REQ;
                    we_d    = in_store;
                    addr_d  = {bus.addr[31:2], 2'b00};
                    be_d    = in_word ? 4'b1111
                            : in_half ? (bus.addr[1] ? 4'b1100 : 4'b0011)
                            : 4'b0001 << bus.addr[1:0];
                    wd_d    = in_word ? bus.wdata
                            : in_half ? {2{bus.wdata[15:0]}}
                            : {4{bus.wdata[7:0]}};
                end
            end
        end else if (state_q == REQ) begin
            cnt_d = cnt_q + 8'd1;
            // an ack on the final allowed cycle still completes without error
            if (bus.mem_ack) begin
                state_d = DONE;
                err_d   = 1'b0;
                rdata_d = q_store ? '0 : load_val;
            end else if (cnt_d == 8'(TIMEOUT)) begin
                state_d = DONE;
                err_d   = 1'b1;
                rdata_d = '0;
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
        end
    end
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = state_q == REQ;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wd_q;
endmodule

// File: doc/lsu_align.md
# lsu_align

Sequential load/store alignment unit between the CPU datapath and the word-wide data memory bus. It narrows register data into byte lanes for SB/SH/SW, extracts and sign- or zero-extends byte/halfword lanes for LB/LBU/LH/LHU/LW, and runs a req/ack handshake with memory, stalling the CPU until the access completes. It is the memory-side counterpart of the immediate extender: it packs narrow data out and widens narrow data back in.

## Interface
- `TIMEOUT`, default 255: cycles `mem_req` may wait for `mem_ack` before the access aborts with a bus error; range 1..255.

- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: access request from the CPU; sampled only in IDLE.
- `op` in 3: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `addr` in 32: byte address.
- `wdata` in 32: store data from the register file.
- `busy` out 1: high whenever state is not IDLE; used as the CPU stall.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; valid while `done` is high and held until the next accepted `start`.
- `err` out 1: qualified by `done`; 1 = timeout or misaligned access.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables, used for both reads and writes.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_ack` is high.
- `mem_ack` in 1: one-cycle acknowledge.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - On `start`=1, latch `op`, `addr` and `wdata`, clear the timeout counter, and go to REQ.
  - Exception: under the misalignment trap (see Configuration), go directly to DONE with `err`=1.
- **REQ**
  - `mem_req`=1; all `mem_*` outputs stay stable.
  - If `mem_ack`=1: capture the read data and go to DONE with `err`=0.
  - Otherwise, increment the counter. When the counter reaches `TIMEOUT`, go to DONE with `err`=1 and `rdata`=0.
- **DONE**: `done`=1 for exactly one cycle, then return to IDLE.
- Byte enables use `a=addr[1:0]`:
  - Byte ops: `mem_be` = 1<<`a`.
  - Half ops: `mem_be` = `addr[1]` ? 4'b1100 : 4'b0011.
  - Word ops: `mem_be` = 4'b1111.
- Store data:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata`.
- Load extraction: take lane = `mem_rdata` >> (8·`a`), or >> (16·`addr[1]`) for halfwords.
  - LB: `{{24{lane[7]}},lane[7:0]}`.
  - LBU: `{24'h0,lane[7:0]}`.
  - LH: `{{16{lane[15]}},lane[15:0]}`.
  - LHU: `{16'h0,lane[15:0]}`.
  - LW: the full word.
- Ignored inputs:
  - `start` while `busy` is ignored and not queued.
  - `mem_ack` outside REQ is ignored.
- `reset` mid-access: at the next edge, state goes to IDLE. No `done` pulse is produced and any pending `mem_ack` is discarded.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `err`=0.
  - `rdata`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- Cycle sequence: `start` sampled at edge 0; `mem_req` rises after edge 0; `mem_ack` sampled at edge N; `done` is high from edge N to edge N+1.
  - Minimum latency is start-to-done 2 cycles (ack in the first REQ cycle).
- `mem_req` falls in the same edge that samples `mem_ack` or reaches the timeout. No back-to-back request occurs without an intervening DONE and IDLE cycle.
- `mem_*` outputs hold their last values in DONE and IDLE; only `mem_req` is deasserted.
- `mem_ack` on exactly the cycle the counter reaches `TIMEOUT`: the ack wins and `err`=0.
- Trapped misaligned access: `start` to `done` is 1 cycle, and `mem_req` never rises.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: halfword ops with `addr[0]`=1, and word ops with `addr[1:0]`≠0, take the trap path (no bus cycle, `err`=1, `rdata`=0).
- Not defined: no trap. Halfword ops use `addr[0]` as 0 and word ops use `addr[1:0]` as 0; the access proceeds normally with `err` from timeout only.

## Test plan
- SB: `addr`=0x00000013, `wdata`=0x123456A5, ack after 3 REQ cycles -> `mem_addr`=0x10, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `done` 4 cycles after `start`, `err`=0.
- LB and LBU: `addr`=0x22, `mem_rdata`=0x11F0_2233 -> LB gives `rdata`=0xFFFFFFF0 and LBU gives 0x000000F0; LH/LHU at `addr`=0x22 give 0x000011F0.
- Timeout: `TIMEOUT`=4, LW with no ack -> `mem_req` high 4 cycles, `done`=1, `err`=1, `rdata`=0; ack arriving 1 cycle later is ignored.
- `start` pulsed while `busy`, and `reset` asserted in REQ -> second request is dropped; after reset, `mem_req`=0, `busy`=0 and no `done` pulse.
- Misaligned SH at `addr`=0x5:
  - With `LSU_MISALIGN_TRAP_EN`: `done`+`err` 1 cycle after `start`, no `mem_req`.
  - Without: `mem_be`=0011, `mem_addr`=0x4.
- Back-to-back SW then LW to the same word, with ack on the first REQ cycle -> LW returns the stored word; each access is start-to-done 2 cycles.
